// File: rtl/npr_inverse_solver_if.sv
// npr_inverse_solver_if: request/result bundle for the nPr inverse solver.
// Optional ovf line present when NPR_INV_OVF_EN is defined.
interface npr_inverse_solver_if #(
  parameter int W = 36
) ();
  logic         start;
  logic [W-1:0] n;
  logic [W-1:0] p;
  logic         busy;
  logic         done;
  logic         found;
  logic [W-1:0] r;
`ifdef NPR_INV_OVF_EN
  logic         ovf;

  modport master (
    output start, n, p,
    input  busy, done, found, r, ovf
  );

  modport slave (
    input  start, n, p,
    output busy, done, found, r, ovf
  );
`else
  modport master (
    output start, n, p,
    input  busy, done, found, r
  );

  modport slave (
    input  start, n, p,
    output busy, done, found, r
  );
`endif
endinterface

// File: rtl/npr_inverse_solver.sv
// npr_inverse_solver: smallest r with n!/(n-r)! == p, one factor per clock.
// Define NPR_INV_OVF_EN to report saturation terminations on io.ovf.
module npr_inverse_solver #(
  parameter int W = 36
) (
  input  logic clk,
  input  logic rst_n,
  npr_inverse_solver_if.slave io
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0] n_q, n_d;
  logic [W-1:0] p_q, p_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] k_q, k_d;
  logic [W-1:0] r_q, r_d;
  logic         sat_q, sat_d;
  logic         done_q, done_d;
  logic         found_q, found_d;
`ifdef NPR_INV_OVF_EN
  logic         ovf_q, ovf_d;
`endif

  logic [W-1:0]   diff;
  logic [2*W-1:0] prod;
  logic           hit;
  logic           miss;
  logic           step;

  // k < n_q whenever a step is taken, so diff never wraps
  assign diff = n_q - k_q;
  assign prod = {{W{1'b0}}, acc_q} * {{W{1'b0}}, diff};

  // hit beats miss beats step; the three are made disjoint here
  assign hit  = !sat_q && (acc_q == p_q);
  assign miss = !hit &&
                (sat_q || (acc_q > p_q) || (k_q == n_q));
  assign step = !hit && !miss;

  assign io.busy  = (state_q == RUN);
  assign io.done  = done_q;
  assign io.found = found_q;
  assign io.r     = r_q;
`ifdef NPR_INV_OVF_EN
  assign io.ovf   = ovf_q;
`endif

  // next-state: latch request in IDLE, one evaluation per RUN cycle
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    p_d     = p_q;
    acc_d   = acc_q;
    k_d     = k_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    found_d = found_q;
    r_d     = r_q;
`ifdef NPR_INV_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          n_d     = io.n;
          p_d     = io.p;
          acc_d   = W'(1);
          k_d     = '0;
          sat_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        unique case (1'b1)
          hit: begin
            found_d = 1'b1;
            r_d     = k_q;
            done_d  = 1'b1;
            state_d = IDLE;
`ifdef NPR_INV_OVF_EN
            ovf_d   = 1'b0;
`endif
          end
          miss: begin
            found_d = 1'b0;
            r_d     = '0;
            done_d  = 1'b1;
            state_d = IDLE;
`ifdef NPR_INV_OVF_EN
            ovf_d   = sat_q;
`endif
          end
          step: begin
            if (|prod[2*W-1:W]) begin
              acc_d = '1;
              sat_d = 1'b1;
            end else begin
              acc_d = prod[W-1:0];
            end
            k_d = k_q + W'(1);
          end
        endcase
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      p_q     <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      r_q     <= '0;
`ifdef NPR_INV_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      p_q     <= p_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
      found_q <= found_d;
      r_q     <= r_d;
`ifdef NPR_INV_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: doc/npr_inverse_solver.md
Name: npr_inverse_solver

Overview:
- Sequential inverse of the permutation-count datapath: given n and a target count p, finds the smallest r with nPr = n!/(n-r)! = p.
- Builds the falling factorial n·(n-1)·…·(n-r+1) one factor per clock and compares each partial product against p.
- Used to recover r from a permutation count produced elsewhere in the CORDIC/combinatorics datapath; 36-bit operands match that datapath.

Parameters:
- W, 36, operand/result width for n, p, r and the accumulator.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- n  input  W  set size (unsigned)
- p  input  W  target permutation count (unsigned)
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when result valid
- found  output  1  valid with done; 1 = exact r exists
- r  output  W  solved r when found=1, else 0; held until next done

Behaviour:
- States: IDLE, RUN. Registers: n_q, p_q, acc (W bits), k (W bits), sat (1 bit).
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, found=0, r=0, acc=0, k=0, sat=0. Reset mid-RUN aborts the search; no done pulse is produced.
- IDLE: on start=1 at an edge:
  - latch n_q=n, p_q=p;
  - set acc=1, k=0, sat=0;
  - go to RUN, busy=1.
  - start while busy is ignored (no queuing).
- RUN: one evaluation per edge, in this priority order:
  1. sat=0 and acc==p_q → found=1, r=k, done=1, go to IDLE.
  2. sat=1, or acc>p_q, or k==n_q → found=0, r=0, done=1, go to IDLE.
  3. Otherwise acc=acc·(n_q-k), computed as a full 2W-bit product. If the upper W bits are nonzero, set acc to all ones and sat=1. Then k=k+1.
- done is high for exactly one cycle and busy falls on the same edge. found and r hold until the next done.
- Latency: if start is sampled at edge E, done is high in the cycle after edge E+1+(final k). The worst case (no match) is n+2 edges.
- Smallest r wins:
  - p=1 returns r=0 for any n, including n=0.
  - When n=1, nP0 = nP1 = 1, so r=0.
  - nP(n-1) = nPn, so r=n-1 is returned, never n.
- p=0 is never matched; it terminates with found=0 at the first evaluation, because acc=1 > 0.
- n=0 with p≠1 gives found=0 after one evaluation, since k==n_q.
- All arithmetic is unsigned. n_q-k never underflows because step 3 requires k<n_q.

Optional Feature:
- Macro: NPR_INV_OVF_EN.
- Defined:
  - adds output port ovf (1 bit), reset 0;
  - ovf is set with done when termination was caused by sat=1, cleared on every other done;
  - lets the caller distinguish "count exceeds W bits" from "no exact r".
- Undefined: no ovf port; overflow terminations report only found=0, r=0. Identical timing either way.

Test Plan:
- n=5, p=60, start pulse → done in the cycle after edge E+4, found=1, r=3, busy high for 4 cycles.
- n=10, p=1 → done in the cycle after edge E+1, found=1, r=0; repeat with n=0, p=1 → same result.
- n=6, p=100 → acc sequence 1, 6, 30, 120; done after edge E+4 with found=0, r=0.
- n=40, p=2^36-1 → product overflows W before matching; found=0, r=0; ovf=1 when NPR_INV_OVF_EN is defined.
- Assert rst_n=0 mid-RUN (n=12, p=479001600) → busy=0, done=0, found=0, r=0 immediately, no done pulse. After release the same request yields found=1, r=11 (the smallest r, not 12).
- start held high continuously with n=4, p=24 → back-to-back searches, each returns found=1, r=3. start pulses while busy are ignored, and done pulses are 5 edges apart.
